// File: rtl/rs_encoder_param.sv
`default_nettype none
// ============================================================================
// Module      : rs_encoder_param
// Description : Systematic Reed-Solomon encoder over GF(2^8) (poly 0x11D,
//               alpha = 0x02). It passes the message symbols through, then
//               appends N-K parity symbols. Valid/ready flow control is
//               supported on both the input and the output side.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_encoder_param #(
    parameter int N   = 255,
    parameter int K   = 239,
    parameter int FCR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_parity,
    output logic       out_last
);

    localparam int         NPAR     = N - K;
    localparam logic [7:0] MSG_LAST = 8'(K - 1);
    localparam logic [7:0] PAR_LAST = 8'(NPAR - 1);

    // GF(2^8) multiply, shift-and-add with reduction by x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    // Generator g(x) = prod (x + alpha^(FCR+i)); byte d holds the coefficient of x^d
    function automatic logic [8*NPAR+7:0] gen_poly();
        logic [8*NPAR+7:0] g;
        logic [7:0]        root;
        int                e;
        g      = '0;
        g[7:0] = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            e    = (FCR + i) % 255;
            root = 8'h01;
            for (int k = 0; k < e; k++) root = gf_mul(root, 8'h02);
            for (int d = i + 1; d >= 1; d--)
                g[8*d +: 8] = g[8*(d-1) +: 8] ^ gf_mul(g[8*d +: 8], root);
            g[7:0] = gf_mul(g[7:0], root);
        end
        return g;
    endfunction

    localparam logic [8*NPAR+7:0] GEN = gen_poly();

    typedef enum logic [0:0] {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       adv;
    logic [7:0] fb;
    logic [7:0] cnt;
    logic [7:0] r     [NPAR];
    logic [7:0] r_nxt [NPAR];

    assign adv = !out_valid || out_ready;
    assign fb  = in_data ^ r[NPAR-1];

    // LFSR next value: division step while in MSG, plain zero-fill shift in PAR
    generate
        for (genvar j = 0; j < NPAR; j++) begin : g_lfsr
            logic [7:0] prev;
            if (j == 0) begin : g_first
                assign prev = 8'h00;
            end else begin : g_rest
                assign prev = r[j-1];
            end
            assign r_nxt[j] = (state == ST_MSG) ? (prev ^ gf_mul(fb, GEN[8*j +: 8])) : prev;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_MSG;
        else        state <= state_nxt;
    end

    // Next-state and input-ready decode; in_ready held low while in reset
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_MSG: begin
                in_ready = rst_n && adv;
                if (in_valid && in_ready && (cnt == MSG_LAST)) state_nxt = ST_PAR;
            end
            ST_PAR: begin
                if (adv && (cnt == PAR_LAST)) state_nxt = ST_MSG;
            end
            default: state_nxt = ST_MSG;
        endcase
    end

    // Output register, LFSR and symbol counter; all frozen while the output stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_parity <= 1'b0;
            out_last   <= 1'b0;
            cnt        <= 8'h00;
            for (int j = 0; j < NPAR; j++) r[j] <= 8'h00;
        end else if (adv) begin
            if (state == ST_MSG) begin
                if (in_valid) begin
                    out_data   <= in_data;
                    out_valid  <= 1'b1;
                    out_parity <= 1'b0;
                    out_last   <= 1'b0;
                    for (int j = 0; j < NPAR; j++) r[j] <= r_nxt[j];
                    cnt <= (cnt == MSG_LAST) ? 8'h00 : cnt + 8'd1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else begin
                out_data   <= r[NPAR-1];
                out_parity <= 1'b1;
                out_valid  <= 1'b1;
                out_last   <= (cnt == PAR_LAST);
                for (int j = 0; j < NPAR; j++) r[j] <= r_nxt[j];
                cnt <= (cnt == PAR_LAST) ? 8'h00 : cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_encoder_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_encoder_param
// Description : Bench for rs_encoder_param. Three instances: RS(3,1), RS(4,2)
//               and the default RS(255,239). Codewords are compared with a
//               long-division reference encoder built on log/antilog tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_encoder_param;

    localparam int N    = 255;
    localparam int K    = 239;
    localparam int FCR  = 0;
    localparam int NPAR = N - K;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // default instance signals
    logic       d_in_valid, d_in_ready, d_out_valid, d_out_parity, d_out_last;
    logic       d_out_ready = 1'b1;
    logic [7:0] d_in_data, d_out_data;
    // RS(3,1) instance signals
    logic       s3_in_valid, s3_in_ready, s3_out_valid, s3_out_parity, s3_out_last;
    logic       s3_out_ready;
    logic [7:0] s3_in_data, s3_out_data;
    // RS(4,2) instance signals
    logic       s4_in_valid, s4_in_ready, s4_out_valid, s4_out_parity, s4_out_last;
    logic       s4_out_ready;
    logic [7:0] s4_in_data, s4_out_data;

    rs_encoder_param #(.N(N), .K(K), .FCR(FCR)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .out_parity(d_out_parity), .out_last(d_out_last)
    );

    rs_encoder_param #(.N(3), .K(1), .FCR(0)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s3_in_valid), .in_ready(s3_in_ready), .in_data(s3_in_data),
        .out_valid(s3_out_valid), .out_ready(s3_out_ready), .out_data(s3_out_data),
        .out_parity(s3_out_parity), .out_last(s3_out_last)
    );

    rs_encoder_param #(.N(4), .K(2), .FCR(0)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_data(s4_in_data),
        .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_data(s4_out_data),
        .out_parity(s4_out_parity), .out_last(s4_out_last)
    );

    // ------------------------------------------------------------------
    // Reference model: GF(2^8) via log/antilog tables, polynomial division
    // ------------------------------------------------------------------
    logic [7:0] gexp [255];
    int         glog [256];
    logic [7:0] gpoly[NPAR+1];   // gpoly[d] = coefficient of x^d

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic build_tables();
        logic [7:0] x;
        logic [7:0] root;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        for (int d = 0; d <= NPAR; d++) gpoly[d] = 8'h00;
        gpoly[0] = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            root = gexp[(FCR + i) % 255];
            for (int d = i + 1; d >= 1; d--) gpoly[d] = gpoly[d-1] ^ gmul(gpoly[d], root);
            gpoly[0] = gmul(gpoly[0], root);
        end
    endtask

    // Entries are {last, parity, data}
    function automatic void rs_ref(input logic [7:0] msg[$], output logic [9:0] exp_cw[$]);
        logic [7:0] c[N];
        logic [7:0] coef;
        for (int i = 0; i < N; i++) c[i] = (i < K) ? msg[i] : 8'h00;
        for (int i = 0; i < K; i++) begin
            coef = c[i];
            for (int d = 0; d <= NPAR; d++) c[i + NPAR - d] = c[i + NPAR - d] ^ gmul(coef, gpoly[d]);
        end
        exp_cw.delete();
        for (int i = 0; i < N; i++)
            exp_cw.push_back((i < K) ? {2'b00, msg[i]} : {(i == N - 1), 1'b1, c[i]});
    endfunction

    // ------------------------------------------------------------------
    // Output monitors (sampled on the falling edge) and ready generator
    // ------------------------------------------------------------------
    logic [9:0] qd[$];
    logic [9:0] q3[$];
    logic [9:0] q4[$];
    int         c4[$];
    int         cyc        = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out   = '0;
    int         stall_err  = 0;
    int         stall_seen = 0;
    logic       rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        d_out_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!d_out_valid || {d_out_last, d_out_parity, d_out_data} !== prev_out))
                stall_err <= stall_err + 1;
            if (d_out_valid && !d_out_ready) stall_seen <= stall_seen + 1;
            prev_stall <= d_out_valid && !d_out_ready;
            prev_out   <= {d_out_last, d_out_parity, d_out_data};
            if (d_out_valid && d_out_ready) qd.push_back({d_out_last, d_out_parity, d_out_data});
            if (s3_out_valid && s3_out_ready) q3.push_back({s3_out_last, s3_out_parity, s3_out_data});
            if (s4_out_valid && s4_out_ready) begin
                q4.push_back({s4_out_last, s4_out_parity, s4_out_data});
                c4.push_back(cyc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Default-instance drivers
    // ------------------------------------------------------------------
    task automatic d_send(input logic [7:0] msg[$], input int gap_pct);
        int i = 0;
        int budget = 0;
        while (i < msg.size() && budget < 20000) begin
            d_in_valid = ($urandom_range(0, 99) >= gap_pct);
            d_in_data  = d_in_valid ? msg[i] : 8'($urandom);
            @(negedge clk);
            if (d_in_valid && d_in_ready) i++;
            @(posedge clk); #1;
            budget++;
        end
        d_in_valid = 1'b0;
        checks++;
        if (i != msg.size()) begin
            errors++;
            $display("FAIL send_timeout: accepted %0d symbols, required %0d", i, msg.size());
        end
    endtask

    task automatic d_collect(input int n, output logic [9:0] got[$]);
        for (int t = 0; t < 5000 && qd.size() < n; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (qd.size() != n) begin
            errors++;
            $display("FAIL collect_count: got %0d symbols, required %0d", qd.size(), n);
        end
        got = qd;
        qd.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_cw(input string name, input logic [9:0] got[$], input int base,
                            input logic [7:0] msg[$]);
        logic [9:0] exp_cw[$];
        logic [9:0] g;
        int         bad = 0;
        rs_ref(msg, exp_cw);
        for (int i = 0; i < N; i++) begin
            g = (base + i < got.size()) ? got[base + i] : 10'h3FF;
            checks++;
            if (g !== exp_cw[i]) begin
                errors++;
                bad++;
                if (bad <= 4)
                    $display("FAIL %s sym%0d: got {last,par,data}=%h, required %h", name, i, g, exp_cw[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        d_in_valid = 1'b1; d_in_data = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({d_out_valid, d_out_data, d_out_parity, d_out_last} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h par=%b last=%b, required all 0",
                     d_out_valid, d_out_data, d_out_parity, d_out_last);
        end
        checks++;
        if ({d_in_ready, s3_in_ready, s4_in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 000", {d_in_ready, s3_in_ready, s4_in_ready});
        end
        d_in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b, required 1 0", d_in_ready, d_out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_n3();
        logic [9:0] exp3[3] = '{10'h001, 10'h103, 10'h302};
        s3_in_valid = 1'b1; s3_in_data = 8'h01;
        @(negedge clk);
        checks++;
        if (s3_in_ready !== 1'b1 || s3_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL n3_pre_edge: got in_ready=%b out_valid=%b, required 1 0", s3_in_ready, s3_out_valid);
        end
        @(posedge clk); #1;
        s3_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (s3_out_valid !== 1'b1 || s3_out_data !== 8'h01) begin
            errors++;
            $display("FAIL n3_latency: got valid=%b data=%h, required 1 01", s3_out_valid, s3_out_data);
        end
        for (int t = 0; t < 20 && q3.size() < 3; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (q3.size() != 3 || s3_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL n3_count: got %0d symbols valid=%b, required 3 0", q3.size(), s3_out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= q3.size() || q3[i] !== exp3[i]) begin
                errors++;
                $display("FAIL n3_sym%0d: got %h, required %h", i, (i < q3.size()) ? q3[i] : 10'h3FF, exp3[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_n4_back_to_back();
        logic [7:0] m4[4]   = '{8'h01, 8'h00, 8'h00, 8'h00};
        logic [9:0] exp4[8] = '{10'h001, 10'h000, 10'h107, 10'h306,
                                10'h000, 10'h000, 10'h100, 10'h300};
        logic acc;
        for (int i = 0; i < 4; i++) begin
            s4_in_valid = 1'b1; s4_in_data = m4[i];
            acc = 1'b0;
            for (int t = 0; t < 10 && !acc; t++) begin
                @(negedge clk);
                acc = s4_in_ready;
                @(posedge clk); #1;
            end
        end
        s4_in_valid = 1'b0;
        for (int t = 0; t < 20 && q4.size() < 8; t++) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q4.size() || q4[i] !== exp4[i]) begin
                errors++;
                $display("FAIL n4_sym%0d: got %h, required %h", i, (i < q4.size()) ? q4[i] : 10'h3FF, exp4[i]);
            end
        end
        checks++;
        if (c4.size() < 8 || c4[7] - c4[0] != 7) begin
            errors++;
            $display("FAIL n4_no_bubble: got span %0d cycles, required 7",
                     (c4.size() >= 8) ? c4[7] - c4[0] : -1);
        end
        @(posedge clk); #1;
    endtask

    logic [9:0] full_cw[$];
    logic [7:0] ramp[$];

    task automatic test_full_rate();
        logic [7:0] a;
        logic [7:0] s;
        rand_ready = 1'b0;
        for (int i = 0; i < K; i++) ramp.push_back(8'(i));
        d_send(ramp, 0);
        d_collect(N, full_cw);
        check_cw("full_rate", full_cw, 0, ramp);
        for (int i = 0; i < NPAR; i++) begin
            a = gexp[(FCR + i) % 255];
            s = 8'h00;
            for (int k = 0; k < full_cw.size(); k++) s = gmul(s, a) ^ full_cw[k][7:0];
            checks++;
            if (s !== 8'h00) begin
                errors++;
                $display("FAIL syndrome%0d: got %h, required 00", i, s);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] got[$];
        int         bad = 0;
        rand_ready = 1'b1;
        d_send(ramp, 30);
        d_collect(N, got);
        rand_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (i >= got.size() || i >= full_cw.size() || got[i] !== full_cw[i]) begin
                errors++;
                bad++;
                if (bad <= 4) $display("FAIL bp_sym%0d: got %h, required %h", i,
                                       (i < got.size()) ? got[i] : 10'h3FF,
                                       (i < full_cw.size()) ? full_cw[i] : 10'h3FF);
            end
        end
        checks++;
        if (stall_err != 0 || stall_seen == 0) begin
            errors++;
            $display("FAIL bp_stall_hold: got %0d unstable stalls over %0d stalls, required 0 over >0",
                     stall_err, stall_seen);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] part[$];
        logic [7:0] msg[$];
        logic [9:0] got[$];
        rand_ready = 1'b0;
        for (int i = 0; i < 100; i++) part.push_back(8'($urandom));
        for (int i = 0; i < K; i++) msg.push_back(8'($urandom));
        d_send(part, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (d_out_valid !== 1'b0 || d_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got out_valid=%b in_ready=%b, required 0 0", d_out_valid, d_in_ready);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        qd.delete();
        @(posedge clk); #1;
        d_send(msg, 0);
        d_collect(N, got);
        check_cw("after_reset", got, 0, msg);
    endtask

    task automatic test_linearity();
        logic [7:0] m1[$];
        logic [7:0] m2[$];
        logic [7:0] m3[$];
        logic [9:0] got[$];
        int         bad = 0;
        for (int i = 0; i < K; i++) begin
            m1.push_back(8'($urandom));
            m2.push_back(8'($urandom));
            m3.push_back(m1[i] ^ m2[i]);
        end
        rand_ready = 1'b1;
        d_send(m1, 10);
        d_send(m2, 10);
        d_send(m3, 10);
        d_collect(3 * N, got);
        rand_ready = 1'b0;
        check_cw("lin_m1", got, 0, m1);
        check_cw("lin_m2", got, N, m2);
        check_cw("lin_m12", got, 2 * N, m3);
        if (got.size() >= 3 * N) begin
            for (int j = K; j < N; j++)
                if (got[2*N + j][7:0] !== (got[j][7:0] ^ got[N + j][7:0])) bad++;
        end else begin
            bad = 1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL linearity: got %0d differing parity symbols, required 0", bad);
        end
    endtask

    initial begin
        d_in_valid  = 1'b0; d_in_data  = 8'h00;
        s3_in_valid = 1'b0; s3_in_data = 8'h00; s3_out_ready = 1'b1;
        s4_in_valid = 1'b0; s4_in_data = 8'h00; s4_out_ready = 1'b1;
        rst_n = 1'b0;
        build_tables();
        test_reset();
        test_n3();
        test_n4_back_to_back();
        test_full_rate();
        test_backpressure();
        test_reset_midstream();
        test_linearity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
